// File: rtl/systolic_feed_scheduler_pkg.sv
// systolic_feed_scheduler_pkg: shared state encoding, default sizes and derived sequence lengths
package systolic_feed_scheduler_pkg;
  localparam int N_DEFAULT = 4;
  localparam int K_DEFAULT = 4;
  localparam int DATA_WIDTH_DEFAULT = 8;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  function automatic int feed_len(input int n, input int k);
    return k + n - 1;
  endfunction
  function automatic int drain_len(input int n);
    return n - 1;
  endfunction
  localparam int FEED_LEN = feed_len(N_DEFAULT, K_DEFAULT);
  localparam int DRAIN_LEN = drain_len(N_DEFAULT);
endpackage

// File: rtl/systolic_feed_scheduler_skew_lane_mux.sv
// systolic_feed_scheduler_skew_lane_mux: picks element (step - LANE) of a latched row/column vector, or 0 outside the wavefront
// Ports: step = feed step counter, vec = K packed operands (element k at [k*DW +: DW]), q = lane operand
module systolic_feed_scheduler_skew_lane_mux #(
  parameter int K = 4,
  parameter int DW = 8,
  parameter int CW = 3,
  parameter int LANE = 0
) (
  input  logic [CW-1:0]   step,
  input  logic [K*DW-1:0] vec,
  output logic [DW-1:0]   q
);
  always_comb begin
    q = '0;
    for (int k = 0; k < K; k++) if (int'(step) == k + LANE) q = vec[k*DW +: DW];
  end
endmodule

// File: rtl/systolic_feed_scheduler.sv
// systolic_feed_scheduler: sequences one skewed NxN systolic matrix-multiply pass (clear, feed, drain, done)
// Ports: clk/rst_n clock and async active-low reset; start/stall control; a_mat/b_mat operand tiles;
//        busy/done status; array_clr/array_we accumulator controls; a_edge/b_edge per-row/column operands
module systolic_feed_scheduler
  import systolic_feed_scheduler_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int K = K_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stall,
  input  logic [N*K*DATA_WIDTH-1:0] a_mat,
  input  logic [K*N*DATA_WIDTH-1:0] b_mat,
  output logic                      busy,
  output logic                      array_clr,
  output logic                      array_we,
  output logic [N*DATA_WIDTH-1:0]   a_edge,
  output logic [N*DATA_WIDTH-1:0]   b_edge,
  output logic                      done
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(K + N);
  localparam logic [CW-1:0] FEED_LAST = CW'(feed_len(N, K) - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(drain_len(N) - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N*K*DW-1:0] a_q;
  logic [K*N*DW-1:0] b_q;
  logic [N-1:0][K*DW-1:0] b_col;
  logic [N*DW-1:0] a_mux, b_mux;
  logic hold;
  // a stall freezes only the active sequence; IDLE and DONE always move on
  assign hold = stall && (state == CLEAR || state == FEED || state == DRAIN);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (!hold)
      case (state)
        IDLE: state_n = start ? CLEAR : IDLE;
        CLEAR: begin
          state_n = FEED;
          cnt_n = '0;
        end
        FEED: begin
          state_n = cnt == FEED_LAST ? DRAIN : FEED;
          cnt_n = cnt == FEED_LAST ? '0 : cnt + 1'b1;
        end
        DRAIN: begin
          state_n = cnt == DRAIN_LAST ? DONE : DRAIN;
          cnt_n = cnt + 1'b1;
        end
        default: state_n = IDLE;
      endcase
  end
  // column j of B gathered into a contiguous vector so both lanes share one mux shape
  genvar i, k;
  for (i = 0; i < N; i++) begin : g_lane
    for (k = 0; k < K; k++) begin : g_col
      assign b_col[i][k*DW +: DW] = b_q[(k*N+i)*DW +: DW];
    end
    systolic_feed_scheduler_skew_lane_mux #(.K(K), .DW(DW), .CW(CW), .LANE(i)) u_a (
      .step(cnt_n),
      .vec (a_q[i*K*DW +: K*DW]),
      .q   (a_mux[i*DW +: DW])
    );
    systolic_feed_scheduler_skew_lane_mux #(.K(K), .DW(DW), .CW(CW), .LANE(i)) u_b (
      .step(cnt_n),
      .vec (b_col[i]),
      .q   (b_mux[i*DW +: DW])
    );
  end
  // outputs are registered from the next state/step so they line up with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
      array_clr <= 1'b0;
      array_we <= 1'b0;
      a_edge <= '0;
      b_edge <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == IDLE && start) begin
        a_q <= a_mat;
        b_q <= b_mat;
      end
      array_clr <= !hold && state_n == CLEAR;
      array_we <= !hold && (state_n == FEED || state_n == DRAIN);
      a_edge <= hold ? a_edge : state_n == FEED ? a_mux : '0;
      b_edge <= hold ? b_edge : state_n == FEED ? b_mux : '0;
    end
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule
